// File: rtl/sorted_stream_out_pkg.sv
// Shared definitions for the sorted-vector read side: element count,
// index width, FSM state encoding and the element slice helper.
package sorted_stream_out_pkg;

    // Element count of the default 64-element sorter (2*n with n=32).
    localparam int unsigned ELEM_COUNT = 64;

    // Index width needed to address 2*half elements (at least one bit).
    function automatic int unsigned idx_width(input int unsigned half);
        return (2 * half <= 2) ? 1 : $clog2(2 * half);
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Bit offset of element idx in a packed vector of width-bit elements.
    function automatic int unsigned elem_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/sorted_elem_mux.sv
// Combinational element selector: picks element [sel] out of a packed
// vector of 2*n WIDTH-bit elements. Also usable as a debug tap on the merger.
module sorted_elem_mux
    import sorted_stream_out_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int n     = 32,
    parameter int IDXW  = idx_width(n)
) (
    input  logic [2*n*WIDTH-1:0] vec,
    input  logic [IDXW-1:0]      sel,
    output logic [WIDTH-1:0]     elem
);

    // Indexed part-select of the requested element.
    assign elem = vec[elem_lsb(32'(sel), WIDTH) +: WIDTH];

endmodule

// File: rtl/sorted_stream_out.sv
// Read side of the odd-even merge sorter: captures the sorted vector on
// start and streams it out one element per accepted beat.
// Optional macro SORT_OUT_DESC_EN: emit the frame largest-first.
module sorted_stream_out
    import sorted_stream_out_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int n     = 32,
    parameter int IDXW  = idx_width(n)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*n*WIDTH-1:0] c_in,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [IDXW-1:0]      out_idx,
    output logic                 out_last,
    output logic                 done
);

    localparam int NE = 2 * n;
    localparam logic [IDXW-1:0] LAST_CNT = IDXW'(NE - 1);

`ifdef SORT_OUT_DESC_EN
    localparam logic [IDXW-1:0] FIRST_POS = LAST_CNT;
`else
    localparam logic [IDXW-1:0] FIRST_POS = '0;
`endif

    state_t               state;
    logic [2*n*WIDTH-1:0] shadow;
    logic [IDXW-1:0]      count;
    logic [IDXW-1:0]      next_count;
    logic [IDXW-1:0]      next_pos;
    logic [WIDTH-1:0]     next_elem;
    logic [WIDTH-1:0]     first_elem;

    // Beat counter always runs 0..NE-1; the emitted position is derived from it.
    assign next_count = count + IDXW'(1);

`ifdef SORT_OUT_DESC_EN
    assign next_pos = LAST_CNT - next_count;
`else
    assign next_pos = next_count;
`endif

    // Next element comes from the frozen shadow copy, never from c_in.
    sorted_elem_mux #(.WIDTH(WIDTH), .n(n), .IDXW(IDXW)) u_next_mux (
        .vec  (shadow),
        .sel  (next_pos),
        .elem (next_elem)
    );

    // First beat is taken straight from c_in so it appears one cycle after start.
    sorted_elem_mux #(.WIDTH(WIDTH), .n(n), .IDXW(IDXW)) u_first_mux (
        .vec  (c_in),
        .sel  (FIRST_POS),
        .elem (first_elem)
    );

    // Capture/stream/done FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shadow    <= '0;
            count     <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        shadow    <= c_in;
                        count     <= '0;
                        state     <= STREAM;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        out_idx   <= FIRST_POS;
                        out_data  <= first_elem;
                        out_last  <= (NE == 1);
                    end
                end
                STREAM: begin
                    if (out_valid && out_ready) begin
                        if (count == LAST_CNT) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            count    <= next_count;
                            out_idx  <= next_pos;
                            out_data <= next_elem;
                            out_last <= (next_count == LAST_CNT);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sorted_stream_out.sv
// Self-checking bench for sorted_stream_out (WIDTH=3, n=32). The reference
// model is the captured vector plus the beat order; honours SORT_OUT_DESC_EN.
module tb_sorted_stream_out;

    localparam int W  = 3;
    localparam int NH = 32;
    localparam int N  = 64;
    localparam int IW = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N*W-1:0] c_in;
    logic           busy;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [IW-1:0]  out_idx;
    logic           out_last;
    logic           done;

    int total = 0;
    int bad   = 0;

`ifdef SORT_OUT_DESC_EN
    bit desc = 1'b1;
`else
    bit desc = 1'b0;
`endif

    sorted_stream_out #(.WIDTH(W), .n(NH), .IDXW(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .c_in      (c_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Advance one edge, then settle so outputs are sampled away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*W-1:0] pattern();
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = W'(k / 8);
        return v;
    endfunction

    function automatic logic [N*W-1:0] fill(input logic [W-1:0] e);
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = e;
        return v;
    endfunction

    function automatic logic [N*W-1:0] rand_vec();
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = W'($urandom_range(0, 7));
        return v;
    endfunction

    // Position in c_in of the j-th beat of a frame.
    function automatic int beat_pos(input int j);
        return desc ? (N - 1 - j) : j;
    endfunction

    task automatic start_frame(input logic [N*W-1:0] v);
        c_in  = v;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called one cycle after the capture edge. mode: 0 continuous ready,
    // 1 random ready, 2 three-cycle stall at beat 5. inj_beat: beat at which
    // a second start with all-7s c_in is attempted (-1 none).
    task automatic run_stream(input string name, input logic [N*W-1:0] v, input int mode,
                              input int inj_beat, input bit clr_cin, input bit restart_in_done);
        int j = 0;
        int hold = 0;
        int guard = 0;
        bit r;
        logic [12:0] exp, got;
        while (j < N && guard < 1000) begin
            exp = {1'b1, 1'b1, IW'(beat_pos(j)), v[beat_pos(j)*W +: W], (j == N - 1), 1'b0};
            got = {out_valid, busy, out_idx, out_data, out_last, done};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL %s beat %0d: got v/b/idx/data/last/done=%b required %b", name, j, got, exp);
            end
            case (mode)
                0: r = 1'b1;
                1: r = ($urandom_range(0, 3) != 0);
                default: begin
                    r = !(j == 5 && hold < 3);
                    if (!r) hold++;
                end
            endcase
            if (j == inj_beat) begin
                start = 1'b1;
                c_in  = fill(3'd7);
            end
            if (clr_cin && guard == 0) c_in = '0;
            out_ready = r;
            tick();
            start = 1'b0;
            guard++;
            if (r) j++;
        end
        if (j < N) begin
            total++;
            bad++;
            $display("FAIL %s timeout: beats=%0d required %0d", name, j, N);
        end
        out_ready = 1'b1;
        total++;
        if ({done, out_valid, busy} !== 3'b101) begin
            bad++;
            $display("FAIL %s done pulse: got done/valid/busy=%b required 101", name, {done, out_valid, busy});
        end
        if (restart_in_done) begin
            start = 1'b1;
            c_in  = v;
        end
        tick();
        start = 1'b0;
        total++;
        if ({done, out_valid, busy} !== 3'b000) begin
            bad++;
            $display("FAIL %s after done: got done/valid/busy=%b required 000", name, {done, out_valid, busy});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; c_in = pattern(); out_ready = 1'b1;
        tick();
        tick();
        total++;
        if ({busy, out_valid, out_data, out_idx, out_last, done} !== '0) begin
            bad++;
            $display("FAIL reset_state: got %b required 0", {busy, out_valid, out_data, out_idx, out_last, done});
        end
        rst = 1'b0; start = 1'b0;
        tick();
        total++;
        if ({busy, out_valid} !== 2'b00) begin
            bad++;
            $display("FAIL reset_priority: got busy/valid=%b required 00", {busy, out_valid});
        end
    endtask

    task automatic test_continuous();
        start_frame(pattern());
        run_stream("continuous", pattern(), 0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        start_frame(pattern());
        run_stream("backpressure", pattern(), 2, -1, 1'b0, 1'b0);
    endtask

    task automatic test_start_during_stream();
        start_frame(pattern());
        run_stream("start_in_stream", pattern(), 0, 10, 1'b0, 1'b0);
        // A single done pulse only: nothing restarts afterwards.
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({done, out_valid, busy} !== 3'b000) begin
                bad++;
                $display("FAIL start_in_stream idle %0d: got done/valid/busy=%b required 000", i, {done, out_valid, busy});
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        start_frame(pattern());
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        total++;
        if (out_idx !== IW'(beat_pos(20))) begin
            bad++;
            $display("FAIL mid_reset pre idx: got %0d required %0d", out_idx, beat_pos(20));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({busy, out_valid, out_data, out_idx, out_last, done} !== '0) begin
            bad++;
            $display("FAIL mid_reset outputs: got %b required 0", {busy, out_valid, out_data, out_idx, out_last, done});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ({done, out_valid, busy} !== 3'b000) begin
                bad++;
                $display("FAIL mid_reset no_done %0d: got done/valid/busy=%b required 000", i, {done, out_valid, busy});
            end
        end
        start_frame(pattern());
        run_stream("after_reset", pattern(), 0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_capture_isolation();
        start_frame(pattern());
        run_stream("capture_isolation", pattern(), 0, -1, 1'b1, 1'b0);
    endtask

    // start held on the edge that re-enters IDLE must be missed.
    task automatic test_back_to_back();
        logic [N*W-1:0] v;
        v = rand_vec();
        start_frame(v);
        run_stream("restart_in_done", v, 0, -1, 1'b0, 1'b1);
        v = rand_vec();
        start_frame(v);
        run_stream("back_to_back", v, 0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [N*W-1:0] v;
        for (int f = 0; f < 4; f++) begin
            v = rand_vec();
            start_frame(v);
            run_stream("random", v, 1, -1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; c_in = '0; out_ready = 1'b1;
        test_reset();
        test_continuous();
        test_backpressure();
        test_start_during_stream();
        test_reset_mid_stream();
        test_capture_isolation();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
